// File: rtl/floor_request_bank_if.sv
// rtl/floor_request_bank_if.sv - call, clear and status signals between the button front end, the bank and the controller
interface floor_request_bank_if #(
  parameter int N_FLOORS = 8
);
  localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;

  logic                hall_valid;
  logic [FW-1:0]       hall_floor;
  logic                hall_dir;
  logic                car_valid;
  logic [FW-1:0]       car_floor;
  logic                clr_valid;
  logic [FW-1:0]       clr_floor;
  logic                clr_dir;
  logic [FW-1:0]       cur_floor;

  logic [N_FLOORS-1:0] up_req;
  logic [N_FLOORS-1:0] down_req;
  logic [N_FLOORS-1:0] car_req;
  logic                any_req;
  logic                req_above;
  logic                req_below;
  logic                req_at_cur;
  logic [N_FLOORS-1:0] starved;
  logic                call_err;

  modport master (
    output hall_valid, hall_floor, hall_dir,
    output car_valid, car_floor,
    output clr_valid, clr_floor, clr_dir,
    output cur_floor,
    input  up_req, down_req, car_req,
    input  any_req, req_above, req_below, req_at_cur,
    input  starved, call_err
  );

  modport slave (
    input  hall_valid, hall_floor, hall_dir,
    input  car_valid, car_floor,
    input  clr_valid, clr_floor, clr_dir,
    input  cur_floor,
    output up_req, down_req, car_req,
    output any_req, req_above, req_below, req_at_cur,
    output starved, call_err
  );
endinterface

// File: rtl/floor_request_bank.sv
// rtl/floor_request_bank.sv - per-floor hall/car call bank with direction summaries and starvation ageing
// N_FLOORS must match the parameter of the connected floor_request_bank_if instance.
module floor_request_bank #(
  parameter int N_FLOORS     = 8,
  parameter int AGE_W        = 8,
  parameter int STARVE_LIMIT = 200
) (
  input logic               clk,
  input logic               rst,
  floor_request_bank_if.slave bus
);
  localparam logic [31:0]      TOP     = 32'(N_FLOORS - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] LIMIT   = AGE_W'(STARVE_LIMIT);

  logic [N_FLOORS-1:0] up_q, down_q, car_q;
  logic [N_FLOORS-1:0] up_d, down_d, car_d;
  logic [N_FLOORS-1:0] pend_q, pend_d;
  logic [AGE_W-1:0]    age_q [N_FLOORS];
  logic                err_q;

  logic [31:0] hall_idx, car_idx, clr_idx, cur_idx;
  logic        hall_ok, hall_rej, car_ok, car_rej, clr_ok;

  logic                any_c, above_c, below_c, at_c;
  logic [N_FLOORS-1:0] starved_c;

  // Floor fields are widened so range checks stay meaningful when N_FLOORS is not a power of two.
  assign hall_idx = 32'(bus.hall_floor);
  assign car_idx  = 32'(bus.car_floor);
  assign clr_idx  = 32'(bus.clr_floor);
  assign cur_idx  = 32'(bus.cur_floor);

  always_comb begin
    hall_ok = 1'b0;
    if (bus.hall_valid && (hall_idx <= TOP)) begin
      if (bus.hall_dir) hall_ok = (hall_idx != TOP);
      else              hall_ok = (hall_idx != 32'd0);
    end
    hall_rej = bus.hall_valid & ~hall_ok;
    car_ok   = bus.car_valid && (car_idx <= TOP);
    car_rej  = bus.car_valid & ~car_ok;
    clr_ok   = bus.clr_valid && (clr_idx <= TOP);
  end

  // Clears are applied after sets so a stop in progress swallows a same-cycle call.
  always_comb begin
    up_d   = up_q;
    down_d = down_q;
    car_d  = car_q;
    if (hall_ok && bus.hall_dir)  up_d[bus.hall_floor]   = 1'b1;
    if (hall_ok && !bus.hall_dir) down_d[bus.hall_floor] = 1'b1;
    if (car_ok)                   car_d[bus.car_floor]   = 1'b1;
    if (clr_ok) begin
      car_d[bus.clr_floor] = 1'b0;
      if (bus.clr_dir) up_d[bus.clr_floor]   = 1'b0;
      else             down_d[bus.clr_floor] = 1'b0;
    end
  end

  assign pend_q = up_q | down_q | car_q;
  assign pend_d = up_d | down_d | car_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      up_q   <= '0;
      down_q <= '0;
      car_q  <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < N_FLOORS; i++) age_q[i] <= '0;
    end else begin
      up_q   <= up_d;
      down_q <= down_d;
      car_q  <= car_d;
      err_q  <= hall_rej | car_rej;
      for (int i = 0; i < N_FLOORS; i++) begin
        if (!pend_d[i] || !pend_q[i])  age_q[i] <= '0;
        else if (age_q[i] != AGE_MAX)  age_q[i] <= age_q[i] + AGE_W'(1);
      end
    end
  end

  always_comb begin
    any_c     = |pend_q;
    above_c   = 1'b0;
    below_c   = 1'b0;
    at_c      = 1'b0;
    starved_c = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      starved_c[i] = (age_q[i] >= LIMIT);
      if (cur_idx <= TOP) begin
        if (32'(i) > cur_idx)  above_c = above_c | pend_q[i];
        if (32'(i) < cur_idx)  below_c = below_c | pend_q[i];
        if (32'(i) == cur_idx) at_c    = at_c    | pend_q[i];
      end
    end
  end

  assign bus.up_req     = up_q;
  assign bus.down_req   = down_q;
  assign bus.car_req    = car_q;
  assign bus.any_req    = any_c;
  assign bus.req_above  = above_c;
  assign bus.req_below  = below_c;
  assign bus.req_at_cur = at_c;
  assign bus.starved    = starved_c;
  assign bus.call_err   = err_q;
endmodule
